// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and the digit type for the BCD scan counter
package bcd_pkg;
   localparam int NDIG = 4;
   typedef logic [3:0] digit_t;
   localparam digit_t BLANK_CODE = 4'hF;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade register with load, up/down step and wrap carry/borrow
module bcd_digit
   import bcd_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_load,
   input  digit_t i_load_d,
   input  logic   i_en,
   input  logic   i_up,
   output digit_t o_q,
   output logic   o_co
);
   digit_t r_q;
   // digit register: reset, then load (out-of-range nibbles become 0), then step
   always_ff @(posedge clk)
      if (rst) r_q <= '0;
      else if (i_load) r_q <= (i_load_d > 4'd9) ? 4'd0 : i_load_d;
      else if (i_en) r_q <= i_up ? ((r_q == 4'd9) ? 4'd0 : r_q + 4'd1)
                                 : ((r_q == 4'd0) ? 4'd9 : r_q - 4'd1);
   assign o_q  = r_q;
   assign o_co = i_en & (i_up ? (r_q == 4'd9) : (r_q == 4'd0));
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: 4-digit BCD up/down counter with multiplexed 7-seg scan outputs
module bcd_scan_counter
   import bcd_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter bit LZ_BLANK = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cnt_en,
   input  logic        up_dn,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] count,
   output logic        carry,
   output logic [3:0]  BCD,
   output logic [3:0]  AN
);
   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   logic [PW-1:0] r_pre;
   logic [1:0]    r_idx;
   logic          r_carry;
   logic [NDIG:0] w_en;
   logic [15:0]   w_count;
   logic [15:0]   w_hi;
   logic          w_blank;
   // load has priority, so it suppresses stepping and the wrap pulse
   assign w_en[0] = cnt_en & ~load;
   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      bcd_digit u_dig (
         .clk      (clk),
         .rst      (rst),
         .i_load   (load),
         .i_load_d (load_val[4*g +: 4]),
         .i_en     (w_en[g]),
         .i_up     (up_dn),
         .o_q      (w_count[4*g +: 4]),
         .o_co     (w_en[g+1])
      );
   end
   // wrap pulse out of the top decade, registered for one cycle
   always_ff @(posedge clk)
      if (rst) r_carry <= 1'b0;
      else r_carry <= w_en[NDIG];
   // scan prescaler and digit index, independent of counting and loading
   always_ff @(posedge clk)
      if (rst) begin
         r_pre <= '0;
         r_idx <= '0;
      end else if (r_pre == PW'(SCAN_DIV - 1)) begin
         r_pre <= '0;
         r_idx <= r_idx + 2'd1;
      end else r_pre <= r_pre + PW'(1);
   // selected digit sits in the low nibble; blank when it and all higher digits are zero
   always_comb begin
      w_hi    = w_count >> {r_idx, 2'b00};
      w_blank = LZ_BLANK && (r_idx != 2'd0) && (w_hi == 16'h0);
   end
   assign count = w_count;
   assign carry = r_carry;
   assign BCD   = w_blank ? BLANK_CODE : w_hi[3:0];
   assign AN    = ~(4'b0001 << r_idx);
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: randomized check of the BCD scan counter against an integer model
module tb_bcd_scan_counter;
   localparam int SD = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b0, cnt_en = 1'b0, up_dn = 1'b0, load = 1'b0;
   logic [15:0] load_val = '0;
   logic [15:0] count;
   logic        carry;
   logic [3:0]  BCD, AN;
   int n_vec = 0, n_err = 0;
   int m_val = 0, m_cyc = 0;
   bit m_carry = 0;

   bcd_scan_counter #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count(count), .carry(carry), .BCD(BCD), .AN(AN)
   );

   always #5 clk = ~clk;

   function automatic int p10(input int i);
      int r = 1;
      for (int k = 0; k < i; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
      return r;
   endfunction

   function automatic int from_load(input logic [15:0] lv);
      int v = 0;
      for (int i = 0; i < 4; i++) begin
         int d = int'(lv[4*i +: 4]);
         v += ((d > 9) ? 0 : d) * p10(i);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit l, input logic [15:0] lv, input bit e, input bit u);
      int idx, hi;
      @(negedge clk);
      rst = r; load = l; load_val = lv; cnt_en = e; up_dn = u;
      @(posedge clk);
      if (r) begin
         m_val = 0; m_carry = 0; m_cyc = 0;
      end else begin
         m_cyc++;
         if (l) begin
            m_val = from_load(lv); m_carry = 0;
         end else if (e && u) begin
            m_carry = (m_val == 9999); m_val = (m_val + 1) % 10000;
         end else if (e) begin
            m_carry = (m_val == 0); m_val = (m_val + 9999) % 10000;
         end else m_carry = 0;
      end
      #1;
      idx = (m_cyc / SD) % 4;
      hi  = m_val / p10(idx);
      chk("count", count, to_bcd(m_val));
      chk("carry", 16'(carry), 16'(m_carry));
      chk("AN", 16'(AN), 16'(4'hF & ~(4'b1 << idx)));
      chk("BCD", 16'(BCD), (idx > 0 && hi == 0) ? 16'hF : 16'(hi % 10));
   endtask

   initial begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
      chk("twelve", count, 16'h0012);
      step(0, 1, 16'h9999, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);
      step(0, 1, 16'h0000, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 16'h0A5F, 0, 0);
      chk("load_sanitize", count, 16'h0050);
      step(0, 1, 16'h0041, 1, 1);
      chk("load_wins", count, 16'h0041);
      step(1, 0, 0, 0, 0);
      step(0, 1, 16'h0042, 0, 0);
      for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 16 && ((m_cyc / SD) % 4) != 2; i++) step(0, 0, 0, 1, 1);
      chk("at_idx2", 16'((m_cyc / SD) % 4), 16'd2);
      step(1, 0, 0, 1, 1);
      chk("rst_an", 16'(AN), 16'hE);
      for (int i = 0; i < 2000; i++) begin
         logic [15:0] lv;
         case ($urandom_range(0, 3))
            0: lv = 16'h9999;
            1: lv = 16'h0000;
            2: lv = 16'h9998;
            default: lv = 16'($urandom);
         endcase
         step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, lv,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
